// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive FIFO for a UART receiver.
// Symbols arrive as single-cycle strobes; the consumer pops with a valid/ready handshake.
// A strobe that meets a full FIFO with no pop in the same cycle is dropped and sets
// a sticky overflow flag.
// Optional feature: define UART_RX_FIFO_LEVEL_EN to add the level_o occupancy output.
module uart_rx_fifo #(
    parameter int MSG_BITS   = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MSG_BITS-1:0] symbol_i,
    input  logic                newSymbol_i,
    output logic [MSG_BITS-1:0] data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                overflow_o,
    input  logic                clearOverflow_i,
    output logic                full_o
`ifdef UART_RX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [MSG_BITS-1:0] r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2:0] r_wptr;
    logic [DEPTH_LOG2:0] r_rptr;
    logic                r_overflow;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // The extra pointer MSB separates "same slot, empty" from "same slot, full".
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]) &&
                     (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]);

    // A pop frees a slot in the same cycle, so a write into a full FIFO is still accepted.
    assign w_pop  = !w_empty && ready_i;
    assign w_push = newSymbol_i && (!w_full || w_pop);
    assign w_drop = newSymbol_i && w_full && !w_pop;

    // Outputs come straight from the pointers, so an asynchronous reset clears them at once.
    assign valid_o    = !w_empty;
    assign full_o     = w_full;
    assign overflow_o = r_overflow;
    assign data_o     = w_empty ? '0 : r_mem[r_rptr[DEPTH_LOG2-1:0]];

`ifdef UART_RX_FIFO_LEVEL_EN
    assign level_o = r_wptr - r_rptr;
`endif

    // Storage array; contents are left unreset because data_o is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= symbol_i;
        end
    end

    // Write and read pointers, wrapping modulo 2^(DEPTH_LOG2+1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Sticky overflow flag; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clearOverflow_i) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (MSG_BITS=8, DEPTH_LOG2=4).
// Honours UART_RX_FIFO_LEVEL_EN when the design is built with it.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] symbol_i;
    logic       newSymbol_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       overflow_o;
    logic       clearOverflow_i;
    logic       full_o;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [4:0] level_o;
`endif

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(
        .MSG_BITS   (8),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .symbol_i        (symbol_i),
        .newSymbol_i     (newSymbol_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .overflow_o      (overflow_o),
        .clearOverflow_i (clearOverflow_i),
        .full_o          (full_o)
`ifdef UART_RX_FIFO_LEVEL_EN
        ,
        .level_o         (level_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit so outputs are sampled off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_next;
        int sent;
        rst = 1'b1;
        symbol_i = 8'h00;
        newSymbol_i = 1'b0;
        ready_i = 1'b0;
        clearOverflow_i = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_valid", valid_o, 0);
        check("rst_full", full_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_data", data_o, 0);
`ifdef UART_RX_FIFO_LEVEL_EN
        check("rst_level", level_o, 0);
`endif
        rst = 1'b0;
        tick();

        // Three writes with ready low, then drain in order
        symbol_i = 8'h41; newSymbol_i = 1'b1;
        tick();
        check("lat_valid", valid_o, 1);
        check("lat_data", data_o, 8'h41);
        symbol_i = 8'h42;
        tick();
        symbol_i = 8'h43;
        tick();
        newSymbol_i = 1'b0;
        ready_i = 1'b1;
        check("drain0", data_o, 8'h41);
        tick();
        check("drain1", data_o, 8'h42);
        tick();
        check("drain2", data_o, 8'h43);
        tick();
        check("drain_empty_valid", valid_o, 0);
        check("drain_empty_data", data_o, 0);
        ready_i = 1'b0;

        // Fill to full, overflow, set-beats-clear, clear, drain
        for (int i = 0; i < 16; i++) begin
            symbol_i = 8'hA0 + 8'(i); newSymbol_i = 1'b1;
            tick();
            if (i == 14) check("full_at15", full_o, 0);
        end
        check("full_at16", full_o, 1);
        check("ovf_before", overflow_o, 0);
        symbol_i = 8'hFF;
        tick();
        newSymbol_i = 1'b0;
        check("ovf_set", overflow_o, 1);
        check("ovf_full", full_o, 1);
        check("ovf_head", data_o, 8'hA0);
        newSymbol_i = 1'b1; clearOverflow_i = 1'b1;
        tick();
        newSymbol_i = 1'b0;
        check("ovf_set_wins", overflow_o, 1);
        tick();
        clearOverflow_i = 1'b0;
        check("ovf_cleared", overflow_o, 0);
        ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain", data_o, 8'hA0 + 8'(i));
            tick();
        end
        check("ovf_drain_empty", valid_o, 0);
        ready_i = 1'b0;

        // Write and pop in the same cycle while full
        for (int i = 0; i < 16; i++) begin
            symbol_i = 8'h20 + 8'(i); newSymbol_i = 1'b1;
            tick();
        end
        symbol_i = 8'h55; newSymbol_i = 1'b1; ready_i = 1'b1;
        tick();
        newSymbol_i = 1'b0;
        check("wp_full", full_o, 1);
        check("wp_ovf", overflow_o, 0);
        check("wp_head", data_o, 8'h21);
        for (int i = 0; i < 15; i++) begin
            check("wp_drain", data_o, 8'h21 + 8'(i));
            tick();
        end
        check("wp_last", data_o, 8'h55);
        tick();
        check("wp_empty", valid_o, 0);
        ready_i = 1'b0;

        // Stream 40 incrementing symbols with ready toggling; crosses pointer wrap
        exp_next = 0;
        sent = 0;
        for (int c = 0; c < 400 && exp_next < 40; c++) begin
            newSymbol_i = ((c % 2) == 0) && (sent < 40);
            symbol_i = 8'(sent);
            ready_i = ((c % 2) == 1);
            #0;
            if (valid_o && ready_i) begin
                check("stream", data_o, exp_next);
                exp_next++;
            end
`ifdef UART_RX_FIFO_LEVEL_EN
            check("stream_level", (level_o <= 5'd16), 1);
`endif
            if (newSymbol_i) sent++;
            tick();
        end
        newSymbol_i = 1'b0; ready_i = 1'b0;
        check("stream_count", exp_next, 40);
        check("stream_ovf", overflow_o, 0);

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            symbol_i = 8'h60 + 8'(i); newSymbol_i = 1'b1;
            tick();
        end
        newSymbol_i = 1'b0;
        check("pre_rst_valid", valid_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_valid", valid_o, 0);
        check("async_full", full_o, 0);
        check("async_ovf", overflow_o, 0);
        check("async_data", data_o, 0);
        tick();
        rst = 1'b0;
        symbol_i = 8'h10; newSymbol_i = 1'b1;
        tick();
        newSymbol_i = 1'b0;
        check("post_rst_valid", valid_o, 1);
        check("post_rst_data", data_o, 8'h10);
        ready_i = 1'b1;
        tick();
        check("post_rst_empty", valid_o, 0);

        // Empty FIFO, strobe with ready held high
        symbol_i = 8'h77; newSymbol_i = 1'b1;
        #0;
        check("pass_valid_before", valid_o, 0);
        tick();
        newSymbol_i = 1'b0;
        check("pass_valid", valid_o, 1);
        check("pass_data", data_o, 8'h77);
`ifdef UART_RX_FIFO_LEVEL_EN
        check("pass_level1", level_o, 1);
`endif
        tick();
        check("pass_gone", valid_o, 0);
        check("pass_gone_data", data_o, 0);
`ifdef UART_RX_FIFO_LEVEL_EN
        check("pass_level0", level_o, 0);
`endif
        ready_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter MSG_BITS, default 8: width of one received symbol.
REQ-002 Parameter DEPTH_LOG2, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default); legal range 1..8.
REQ-003 One clock, clk; reset rst is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 symbol_i  input  MSG_BITS  received symbol from the upstream UART receiver.
REQ-007 newSymbol_i  input  1  single-cycle strobe; symbol_i is valid in that cycle.
REQ-008 data_o  output  MSG_BITS  oldest stored symbol (first-word-fall-through).
REQ-009 valid_o  output  1  FIFO non-empty; data_o is valid.
REQ-010 ready_i  input  1  consumer accepts data_o; a pop occurs when valid_o && ready_i.
REQ-011 overflow_o  output  1  sticky flag: a symbol was dropped.
REQ-012 clearOverflow_i  input  1  synchronous clear of overflow_o.
REQ-013 full_o  output  1  all 2^DEPTH_LOG2 entries occupied.

Function
REQ-014 Storage: 2^DEPTH_LOG2 x MSG_BITS array; write and read pointers are DEPTH_LOG2+1 bits wide, and the MSB distinguishes full from empty.
REQ-015 Empty when the pointers are equal; full when the low bits are equal and the MSBs differ; pointers wrap modulo 2^(DEPTH_LOG2+1).
REQ-016 Write: when newSymbol_i=1 and (not full, or a pop occurs in the same cycle), store symbol_i at the write pointer and increment it.
REQ-017 Pop: when valid_o=1 and ready_i=1, increment the read pointer; ready_i is ignored when valid_o=0.
REQ-018 Latency: a symbol written at edge N appears on data_o with valid_o=1 after edge N; there is no same-cycle bypass from symbol_i to data_o.
REQ-019 data_o is 0 whenever valid_o=0.
REQ-020 Simultaneous write and pop while non-empty: occupancy is unchanged and both pointers advance.
REQ-021 Simultaneous write and pop while full: the write is accepted, full_o stays 1, and overflow_o is unchanged.
REQ-022 Write while full with no pop: the symbol is discarded, the stored contents are unchanged, and overflow_o is set to 1 at the next edge.
REQ-023 overflow_o holds until clearOverflow_i=1; if clear and a new drop occur in the same cycle, set wins.
REQ-024 Symbol order is strictly preserved; no symbol is duplicated or reordered across pointer wrap.

Reset
REQ-025 While rst=1: both pointers are 0, valid_o=0, full_o=0, overflow_o=0, and data_o=0, regardless of clk.
REQ-026 Array contents are not reset; they are never visible because data_o is masked while empty.
REQ-027 Reset asserted mid-operation discards all stored symbols; the first write after release lands at entry 0.

Configuration
REQ-028 Macro UART_RX_FIFO_LEVEL_EN; when defined, add output level_o (DEPTH_LOG2+1 bits) equal to the current occupancy (write pointer minus read pointer), updated on the same edge as the pointers, 0 in reset.
REQ-029 When UART_RX_FIFO_LEVEL_EN is undefined, level_o does not exist and all other behaviour is identical.

Verification
REQ-030 Write 0x41,0x42,0x43 on three strobes with ready_i=0, then raise ready_i -> data_o shows 0x41,0x42,0x43 on consecutive cycles, then valid_o=0 and data_o=0.
REQ-031 Write 16 symbols with DEPTH_LOG2=4 -> full_o=1 after the 16th; a 17th strobe of 0xFF -> overflow_o=1 and the drained sequence contains no 0xFF; clearOverflow_i pulse -> overflow_o=0.
REQ-032 With the FIFO full, strobe 0x55 with ready_i=1 in the same cycle -> the oldest entry pops, 0x55 is stored last, full_o stays 1, and overflow_o stays 0.
REQ-033 Stream 40 incrementing symbols with ready_i toggling every cycle -> the output is exactly 0..39 in order across pointer wrap (level_o never exceeds 16 when enabled).
REQ-034 Store 5 symbols, then assert rst asynchronously between edges -> valid_o, full_o, and overflow_o go to 0 immediately; after release, a write of 0x10 appears as data_o=0x10 one cycle later.
REQ-035 Empty FIFO, newSymbol_i=1 with ready_i=1 held -> valid_o rises one cycle after the strobe and pops on that cycle; with the macro, level_o reads 1 for exactly one cycle.
